// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   funct3_e    - access size/sign encodings carried on Funct3
//   lsu_state_e - transaction FSM states
//   BE_*        - byte-enable patterns for lane 0; these are shifted by the byte offset
package lsu_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational lane logic for the load/store unit.
//   funct3_i      - access size/sign; encodings outside funct3_e behave as a word
//   offset_i      - byte offset within the word (address bits [1:0])
//   store_data_i  - raw store value (rs2)
//   rdata_i       - raw word returned by memory
//   be_o          - byte enables for the access
//   wdata_o       - store data replicated across every lane of its size
//   load_data_o   - read data shifted down to bit 0, then sign- or zero-extended
//   misaligned_o  - access crosses its natural alignment boundary
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3_i,
  input  logic [1:0]            offset_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [3:0]            be_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [DATA_WIDTH-1:0] load_data_o,
  output logic                  misaligned_o
);

  logic [DATA_WIDTH-1:0] shifted;

  // Addressed byte/halfword moved down to lane 0.
  assign shifted = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    // Word access is the default, which also covers unsupported encodings.
    be_o         = BE_WORD;
    wdata_o      = store_data_i;
    load_data_o  = shifted;
    misaligned_o = (offset_i != 2'b00);
    case (funct3_i)
      F3_B, F3_BU: begin
        be_o         = BE_BYTE << offset_i;
        wdata_o      = {(DATA_WIDTH/8){store_data_i[7:0]}};
        misaligned_o = 1'b0;
        load_data_o  = {{(DATA_WIDTH-8){(funct3_i == F3_B) & shifted[7]}}, shifted[7:0]};
      end
      F3_H, F3_HU: begin
        be_o         = BE_HALF << offset_i;
        wdata_o      = {(DATA_WIDTH/16){store_data_i[15:0]}};
        misaligned_o = offset_i[0];
        load_data_o  = {{(DATA_WIDTH-16){(funct3_i == F3_H) & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory stage behind the ALU. Turns MemRead/MemWrite into a
// single word-aligned req/ack transaction and stalls the pipeline meanwhile.
//   clk, reset            - clock, asynchronous active-low reset
//   MemRead, MemWrite     - load/store request (MemRead wins if both set)
//   Funct3                - access size/sign
//   ALUResult, StoreData  - effective byte address, store value
//   LoadData, LoadValid   - formatted load result (held), one-cycle valid pulse
//   Stall                 - freeze upstream while a transaction is pending
//   MisalignErr, BusErr   - one-cycle misalignment / timeout flags
//   mem_req .. mem_be     - memory request side, stable for the whole BUSY phase
//   mem_rdata, mem_ack    - memory response side
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] StoreData,
  output logic [DATA_WIDTH-1:0] LoadData,
  output logic                  LoadValid,
  output logic                  Stall,
  output logic                  MisalignErr,
  output logic                  BusErr,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Last BUSY cycle index (counting from 0) that still waits for an ack.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q, load_q;
  logic [3:0]            be_q;
  logic                  we_q, buserr_q;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;

  logic                  idle, issue, ack_take, timeout;
  logic [2:0]            al_f3;
  logic [1:0]            al_off;
  logic [3:0]            al_be;
  logic [DATA_WIDTH-1:0] al_wdata, al_load;
  logic                  al_mis;

  // The aligner encodes the incoming request while IDLE and formats the
  // response using the captured size/offset otherwise; the two uses never
  // overlap, so one instance serves both.
  assign idle   = (state_q == IDLE);
  assign al_f3  = idle ? Funct3 : f3_q;
  assign al_off = idle ? ALUResult[1:0] : off_q;

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .funct3_i     (al_f3),
    .offset_i     (al_off),
    .store_data_i (StoreData),
    .rdata_i      (mem_rdata),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .load_data_o  (al_load),
    .misaligned_o (al_mis)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    Stall       = 1'b0;
    mem_req     = 1'b0;
    MisalignErr = 1'b0;
    issue       = 1'b0;
    ack_take    = 1'b0;
    timeout     = 1'b0;
    case (state_q)
      IDLE: begin
        // Gating with reset keeps the combinational outputs low while reset is held.
        if (reset && (MemRead || MemWrite)) begin
          if (al_mis) begin
            MisalignErr = 1'b1;
          end else begin
            Stall   = 1'b1;
            issue   = 1'b1;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        Stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) begin
          ack_take = 1'b1;
          state_d  = RESP;
          cnt_d    = '0;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // The pipeline still presents the completed op here; ignore it.
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      load_q   <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
      buserr_q <= 1'b0;
      f3_q     <= '0;
      off_q    <= '0;
    end else begin
      if (issue) begin
        addr_q   <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
        wdata_q  <= al_wdata;
        be_q     <= al_be;
        we_q     <= ~MemRead;
        f3_q     <= Funct3;
        off_q    <= ALUResult[1:0];
        buserr_q <= 1'b0;
      end
      if (ack_take && !we_q) begin
        load_q <= al_load;
      end
      if (timeout) begin
        load_q   <= '0;
        buserr_q <= 1'b1;
      end
    end
  end

  assign LoadData  = load_q;
  assign LoadValid = (state_q == RESP) && !we_q;
  assign BusErr    = (state_q == RESP) && buserr_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, mem_ack;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult, StoreData, mem_rdata;
  logic [31:0] LoadData, mem_addr, mem_wdata;
  logic        LoadValid, Stall, MisalignErr, BusErr, mem_req, mem_we;
  logic [3:0]  mem_be;

  int          checks = 0;
  int          errors = 0;
  int          txn = 0;
  logic [31:0] exp_load;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .Funct3      (Funct3),
    .ALUResult   (ALUResult),
    .StoreData   (StoreData),
    .LoadData    (LoadData),
    .LoadValid   (LoadValid),
    .Stall       (Stall),
    .MisalignErr (MisalignErr),
    .BusErr      (BusErr),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes from Funct3 (anything unknown is a word).
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  // Store data: lane i carries byte (i mod size) of the store value.
  function automatic logic [31:0] repl(input logic [31:0] sd, input int sz);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % sz) +: 8];
    return w;
  endfunction

  // Load data: shift, keep size bytes, extend according to signedness.
  function automatic logic [31:0] fmt(input logic [31:0] rdata, input logic [2:0] f3, input logic [1:0] off);
    int sz;
    logic [31:0] v, mask;
    sz = size_of(f3);
    v  = rdata >> (8 * int'(off));
    if (sz < 4) begin
      mask = (32'd1 << (8 * sz)) - 32'd1;
      v    = v & mask;
      if ((f3 == 3'b000 || f3 == 3'b001) && v[8*sz-1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic idle_inputs();
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Funct3    = 3'b000;
    ALUResult = $urandom;
    StoreData = $urandom;
  endtask

  // One complete transaction. ack_at = BUSY cycle (1-based) in which mem_ack is
  // given; 0 means never acknowledge (timeout expected after TO BUSY cycles).
  task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd,
                       input logic [31:0] rdata, input int ack_at);
    int          sz, n;
    bit          mis, tmo;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    sz  = size_of(f3);
    mis = (int'(addr[1:0]) % sz) != 0;
    ebe = 4'(((1 << sz) - 1) << int'(addr[1:0]));
    ewd = repl(sd, sz);
    txn++;
    @(negedge clk);
    MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = addr; StoreData = sd;
    #1;
    if (mis) begin
      chk1("misalign_flag", MisalignErr, 1'b1);
      chk1("misalign_stall", Stall, 1'b0);
      chk1("misalign_req", mem_req, 1'b0);
      @(negedge clk);
      idle_inputs();
      #1;
      chk1("misalign_pulse_end", MisalignErr, 1'b0);
      chk1("misalign_no_req", mem_req, 1'b0);
      $display("txn %0d rd=%b wr=%b f3=%0d addr=%08h misaligned", txn, rd, wr, f3, addr);
      return;
    end
    chk1("issue_stall", Stall, 1'b1);
    chk1("issue_misalign", MisalignErr, 1'b0);
    chk1("issue_req_low", mem_req, 1'b0);
    n   = 0;
    tmo = 1'b0;
    while (1) begin
      @(negedge clk);
      n++;
      chk1("busy_req", mem_req, 1'b1);
      chk1("busy_stall", Stall, 1'b1);
      chk("busy_addr", mem_addr, {addr[31:2], 2'b00});
      chk("busy_be", 32'(mem_be), 32'(ebe));
      chk1("busy_we", mem_we, !rd);
      if (!rd) chk("busy_wdata", mem_wdata, ewd);
      if (ack_at != 0 && n == ack_at) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        break;
      end
      if (n >= TO) begin
        tmo = 1'b1;
        break;
      end
    end
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    #1;
    if (tmo) exp_load = 32'h0;
    else if (rd) exp_load = fmt(rdata, f3, addr[1:0]);
    chk1("resp_stall", Stall, 1'b0);
    chk1("resp_req", mem_req, 1'b0);
    chk1("resp_valid", LoadValid, rd);
    chk1("resp_buserr", BusErr, tmo);
    chk("resp_loaddata", LoadData, exp_load);
    @(negedge clk);
    idle_inputs();
    #1;
    chk1("post_req", mem_req, 1'b0);
    chk1("post_stall", Stall, 1'b0);
    chk1("post_valid", LoadValid, 1'b0);
    chk1("post_buserr", BusErr, 1'b0);
    $display("txn %0d rd=%b wr=%b f3=%0d addr=%08h sd=%08h ack_at=%0d busy=%0d timeout=%b LoadData=%08h",
             txn, rd, wr, f3, addr, sd, ack_at, n, tmo, LoadData);
  endtask

  initial begin
    reset     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    exp_load  = 32'h0;
    MemRead   = 1'b1;
    MemWrite  = 1'b0;
    Funct3    = 3'b010;
    ALUResult = 32'h0000_0100;
    StoreData = 32'h1234_5678;

    // Reset state: outputs low even with a request presented.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_loaddata", LoadData, 32'h0);
    chk1("rst_valid", LoadValid, 1'b0);
    chk1("rst_stall", Stall, 1'b0);
    chk1("rst_misalign", MisalignErr, 1'b0);
    chk1("rst_buserr", BusErr, 1'b0);
    chk1("rst_req", mem_req, 1'b0);
    chk1("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_be", 32'(mem_be), 32'h0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;

    // Directed scenarios.
    do_op(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 2);   // SW, ack on 2nd BUSY cycle
    do_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 1);   // LB  -> FFFFFF80
    do_op(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 1);   // LBU -> 00000080
    do_op(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_1234, 32'h0, 1);   // SH  -> be 1100
    do_op(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'h0, 1);           // LW misaligned
    do_op(1'b1, 1'b0, 3'b001, 32'h0000_0206, 32'h0, 32'h8001_7FFF, 3);   // LH upper half
    do_op(1'b1, 1'b1, 3'b101, 32'h0000_0004, 32'h0, 32'hF00D_9ABC, 1);   // both set: read wins
    do_op(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h0, 0);           // LW timeout

    // Reset while BUSY abandons the access; a later ack is ignored.
    txn++;
    @(negedge clk);
    MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h0000_0300;
    @(negedge clk);
    #1;
    chk1("pre_rst_busy_req", mem_req, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    exp_load = 32'h0;
    chk1("midrst_req", mem_req, 1'b0);
    chk1("midrst_stall", Stall, 1'b0);
    chk("midrst_loaddata", LoadData, exp_load);
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    #1;
    chk1("spurious_ack_req", mem_req, 1'b0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk1("spurious_ack_valid", LoadValid, 1'b0);
    chk("spurious_ack_loaddata", LoadData, exp_load);
    $display("txn %0d reset during BUSY, spurious ack afterwards", txn);
    do_op(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic       r, w;
      logic [2:0] f;
      int         a;
      r = 1'($urandom_range(0, 1));
      w = r ? 1'($urandom_range(0, 1)) : 1'b1;
      f = 3'($urandom_range(0, 7));
      a = (i % 10 == 9) ? 0 : int'($urandom_range(1, 4));
      do_op(r, w, f, $urandom, $urandom, $urandom, a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
